// File: rtl/aes_decipher.sv
`default_nettype none
// ============================================================================
// Module   : aes_decipher
// Purpose  : Iterative AES inverse cipher, one round per clock. Supports
//            AES-128 (10 rounds) and AES-256 (14 rounds), chosen per
//            operation. Round keys are requested by index from an external
//            key-expansion block, counting down from Nr to 0.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - asynchronous reset, active-high
//            next       - start request, sampled only while idle
//            keylen     - 0 = AES-128, 1 = AES-256, latched with next
//            abort      - (only with AES_DEC_ABORT_EN) cancel the running op
//            round      - round-key index requested this cycle
//            round_key  - key for index `round`, valid in the same cycle
//            block      - ciphertext, sampled at the end of the INIT cycle
//            new_block  - state register; plaintext when ready pulses
//            ready      - one-cycle pulse, new_block holds valid plaintext
// Macros   : AES_DEC_ABORT_EN - adds the abort input and its behaviour
// Revision : 1.0 - initial release
// ============================================================================
module aes_decipher #(
   parameter int AES128_ROUNDS = 10,
   parameter int AES256_ROUNDS = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         next,
   input  logic         keylen,
`ifdef AES_DEC_ABORT_EN
   input  logic         abort,
`endif
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      INIT = 2'b01,
      MAIN = 2'b10
   } state_t;

   localparam logic [3:0] c_nr128 = 4'(AES128_ROUNDS);
   localparam logic [3:0] c_nr256 = 4'(AES256_ROUNDS);

   localparam logic [7:0] c_inv_sbox [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // GF(2^8) multiply by a 4-bit constant, built from repeated doubling.
   function automatic logic [7:0] gf_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mulc(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] m2;
      logic [7:0] m4;
      logic [7:0] m8;
      m2 = gf_xtime(b);
      m4 = gf_xtime(m2);
      m8 = gf_xtime(m4);
      return (k[3] ? m8 : 8'h00) ^ (k[2] ? m4 : 8'h00) ^
             (k[1] ? m2 : 8'h00) ^ (k[0] ? b  : 8'h00);
   endfunction

   // One column, row 0 in the top byte.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mulc(a0, 4'he) ^ gf_mulc(a1, 4'hb) ^ gf_mulc(a2, 4'hd) ^ gf_mulc(a3, 4'h9),
              gf_mulc(a0, 4'h9) ^ gf_mulc(a1, 4'he) ^ gf_mulc(a2, 4'hb) ^ gf_mulc(a3, 4'hd),
              gf_mulc(a0, 4'hd) ^ gf_mulc(a1, 4'h9) ^ gf_mulc(a2, 4'he) ^ gf_mulc(a3, 4'hb),
              gf_mulc(a0, 4'hb) ^ gf_mulc(a1, 4'hd) ^ gf_mulc(a2, 4'h9) ^ gf_mulc(a3, 4'he)};
   endfunction

   state_t         state_q, state_d;
   logic [3:0]     round_q, round_d;
   logic [127:0]   new_block_q, new_block_d;
   logic           ready_q, ready_d;
   logic           keylen_q, keylen_d;

   logic [127:0]   w_sub;    // InvShiftRows + InvSubBytes of the state
   logic [127:0]   w_addk;   // ... then AddRoundKey
   logic [127:0]   w_mix;    // ... then InvMixColumns

   // Byte i sits at bits [127-8i -: 8], row = i%4, col = i/4. Row r is
   // rotated right by r, so output (r,c) takes input (r, (c-r) mod 4).
   generate
      for (genvar i = 0; i < 16; i++) begin : g_byte
         localparam int ROW = i % 4;
         localparam int COL = i / 4;
         localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
         assign w_sub[127 - 8*i -: 8] = c_inv_sbox[new_block_q[127 - 8*SRC -: 8]];
      end
   endgenerate

   assign w_addk = w_sub ^ round_key;

   generate
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_mix[127 - 32*c -: 32] = inv_mix_col(w_addk[127 - 32*c -: 32]);
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      new_block_d = new_block_q;
      keylen_d    = keylen_q;
      ready_d     = 1'b0;
      case (state_q)
         IDLE: begin
            round_d = 4'd0;
            if (next) begin
               keylen_d = keylen;
               round_d  = keylen ? c_nr256 : c_nr128;
               state_d  = INIT;
            end
         end
         INIT: begin
            new_block_d = block ^ round_key;
            round_d     = (keylen_q ? c_nr256 : c_nr128) - 4'd1;
            state_d     = MAIN;
         end
         MAIN: begin
            if (round_q != 4'd0) begin
               new_block_d = w_mix;
               round_d     = round_q - 4'd1;
            end else begin
               // Final round skips InvMixColumns.
               new_block_d = w_addk;
               ready_d     = 1'b1;
               round_d     = 4'd0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef AES_DEC_ABORT_EN
      // Abort takes priority over everything, including the final round.
      if (abort && (state_q == INIT || state_q == MAIN)) begin
         state_d     = IDLE;
         round_d     = 4'd0;
         new_block_d = '0;
         ready_d     = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         round_q     <= 4'd0;
         new_block_q <= '0;
         ready_q     <= 1'b0;
         keylen_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         new_block_q <= new_block_d;
         ready_q     <= ready_d;
         keylen_q    <= keylen_d;
      end
   end

   assign round     = round_q;
   assign new_block = new_block_q;
   assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decipher
// Purpose  : Self-checking bench for aes_decipher. A behavioural AES model
//            (S-box derived from GF(2^8) inversion, FIPS key expansion,
//            matrix-form inverse cipher) supplies expected plaintext; known
//            answer vectors are checked against fixed constants.
// Macros   : AES_DEC_ABORT_EN - also exercises the abort input
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decipher;

   logic         clk = 1'b0;
   logic         rst;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;
`ifdef AES_DEC_ABORT_EN
   logic         abort;
`endif

   logic [127:0] rk [15];
   logic [7:0]   sb  [256];
   logic [7:0]   isb [256];
   logic [127:0] last_pt;
   int           n_checks = 0;
   int           n_errors = 0;

   aes_decipher dut (
      .clk       (clk),
      .rst       (rst),
      .next      (next),
      .keylen    (keylen),
`ifdef AES_DEC_ABORT_EN
      .abort     (abort),
`endif
      .round     (round),
      .round_key (round_key),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   // Key-expansion block stand-in: key for the requested index, same cycle.
   assign round_key = (round <= 4'd14) ? rk[round] : '0;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand_key(input bit kl, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   base [4];
      logic [7:0]   acc;
      logic [127:0] out;
      base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = ct[127 - 8*(4*c+r) -: 8] ^ rk[nr][127 - 8*(4*c+r) -: 8];
      for (int rnd = nr - 1; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = isb[s[r][(c - r + 4) % 4]] ^ rk[rnd][127 - 8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               if (rnd > 0) begin
                  acc = 8'h00;
                  for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], t[k][c]);
                  s[r][c] = acc;
               end else begin
                  s[r][c] = t[r][c];
               end
            end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            out[127 - 8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   // Starts an op from a negedge; returns at the negedge just after next is sampled.
   task automatic launch(input bit kl, input logic [255:0] key, input logic [127:0] blk,
                         input bit hold, output logic [127:0] exp);
      expand_key(kl, key);
      exp    = ref_decrypt(blk, kl ? 14 : 10);
      keylen = kl;
      block  = blk;
      next   = 1'b1;
      @(negedge clk);
      if (!hold) next = 1'b0;
   endtask

   // flags[0]: flip keylen at cycle 3; flags[1]: pulse next during MAIN.
   task automatic wait_ready(input int nr, input logic [127:0] exp, input int flags);
      int n, bad;
      logic [3:0] er;
      n = 0; bad = 0;
      while (!ready && n <= 40) begin
         er = (n == 0) ? 4'(nr) : ((n <= nr) ? 4'(nr - n) : 4'd0);
         if (round !== er) bad++;
         if (flags[0] && n == 3) keylen = ~keylen;
         if (flags[1] && n == 5) next = 1'b1;
         if (flags[1] && n == 6) next = 1'b0;
         @(negedge clk);
         n++;
      end
      if (round !== 4'd0) bad++;
      check_value("round_seq", 128'(bad), 128'd0);
      check_value("latency", 128'(n), 128'(nr + 1));
      check_value("plaintext", new_block, exp);
   endtask

   task automatic do_op(input bit kl, input logic [255:0] key, input logic [127:0] blk,
                        input bit use_kat, input logic [127:0] kat, input int flags);
      logic [127:0] exp;
      int cnt;
      launch(kl, key, blk, 1'b0, exp);
      if (use_kat) exp = kat;
      wait_ready(kl ? 14 : 10, exp, flags);
      @(negedge clk);
      check_value("ready_pulse", 128'(ready), 128'd0);
      check_value("hold", new_block, exp);
      if (flags[1]) begin
         cnt = 0;
         repeat (16) begin
            @(negedge clk);
            if (ready || round != 4'd0) cnt++;
         end
         check_value("no_extra_op", 128'(cnt), 128'd0);
      end
      last_pt = exp;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] e1, e2;
      logic [255:0] k;
      logic [127:0] b;
      int cnt;
      rst = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
`ifdef AES_DEC_ABORT_EN
      abort = 1'b0;
`endif
      for (int i = 0; i < 15; i++) rk[i] = '0;
      for (int x = 0; x < 256; x++) begin
         sb[x] = sbox_calc(8'(x));
         isb[sb[x]] = 8'(x);
      end

      repeat (2) @(negedge clk);
      check_value("rst_round", 128'(round), 128'd0);
      check_value("rst_block", new_block, 128'd0);
      check_value("rst_ready", 128'(ready), 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // Known-answer vectors
      do_op(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'd0},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 128'h00112233445566778899aabbccddeeff, 0);
      do_op(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, 128'h00112233445566778899aabbccddeeff, 0);

      // keylen flipped mid-op, then next pulsed during MAIN
      do_op(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'd0},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 128'h00112233445566778899aabbccddeeff, 1);
      do_op(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'd0},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 2);

      // Back-to-back: next held through the first ready pulse
      launch(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'd0},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, e1);
      wait_ready(10, e1, 0);
      expand_key(1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      b = {$urandom, $urandom, $urandom, $urandom};
      e2 = ref_decrypt(b, 14);
      keylen = 1'b1;
      block  = b;
      @(negedge clk);
      next = 1'b0;
      check_value("b2b_ready_low", 128'(ready), 128'd0);
      wait_ready(14, e2, 0);
      @(negedge clk);
      check_value("b2b_ready_pulse", 128'(ready), 128'd0);

      // Asynchronous reset in the middle of an op
      launch(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'd0},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, e1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_value("midrst_round", 128'(round), 128'd0);
      check_value("midrst_block", new_block, 128'd0);
      check_value("midrst_ready", 128'(ready), 128'd0);
      #1 rst = 1'b0;
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (ready) cnt++;
      end
      check_value("midrst_no_ready", 128'(cnt), 128'd0);
      do_op(1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 0);

`ifdef AES_DEC_ABORT_EN
      // Abort while idle leaves the held plaintext alone
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_value("abort_idle_hold", new_block, last_pt);
      // Abort at round 4 of an AES-256 op
      launch(1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, e1);
      for (int w = 0; w < 30 && round != 4'd4; w++) @(negedge clk);
      check_value("abort_reach", 128'(round), 128'd4);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_value("abort_round", 128'(round), 128'd0);
      check_value("abort_block", new_block, 128'd0);
      check_value("abort_ready", 128'(ready), 128'd0);
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (ready) cnt++;
      end
      check_value("abort_no_ready", 128'(cnt), 128'd0);
      do_op(1'b0, {$urandom, $urandom, $urandom, $urandom, 128'd0},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 0);
`endif

      // Randomized operations
      for (int i = 0; i < 6; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         do_op(1'($urandom_range(0, 1)), k, b, 1'b0, '0, int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
